// File: rtl/bitorder_cksum_aggregate_pkg.sv
// Purpose: shared CRC-32 constants, aggregate length and the bit-step helper.
// Latency: n/a (constants and a combinational function only).
// Backpressure: n/a.
package bitorder_cksum_aggregate_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          AGG_DIBITS    = 16;

  typedef logic [1:0] dibit_t;

  // One reflected CRC-32 step for a single wire bit.
  function automatic logic [31:0] crc_bit_step(input logic [31:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? CRC_POLY_REFL : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/bitorder_cksum_aggregate_if.sv
// Purpose: bundles the rx, reorder, aggregate and checksum-status signals.
// Latency: n/a (wiring only).
// Backpressure: none; every stream is valid-only.
interface bitorder_cksum_aggregate_if;
  import bitorder_cksum_aggregate_pkg::*;

  logic        rx_axiiv;
  dibit_t      rx_axiid;
  logic        bo_axiov;
  dibit_t      bo_axiod;
  logic        ag_axiiv;
  dibit_t      ag_axiid;
  logic        ag_axiov;
  logic [31:0] ag_axiod;
  logic        ck_done;
  logic        ck_kill;

  modport master (
    output rx_axiiv, rx_axiid, ag_axiiv, ag_axiid,
    input  bo_axiov, bo_axiod, ag_axiov, ag_axiod, ck_done, ck_kill
  );

  modport slave (
    input  rx_axiiv, rx_axiid, ag_axiiv, ag_axiid,
    output bo_axiov, bo_axiod, ag_axiov, ag_axiod, ck_done, ck_kill
  );

endinterface

// File: rtl/crc32_dibit_step.sv
// Purpose: advances a reflected CRC-32 register by one dibit (bit0 first, then bit1).
// Latency: combinational.
// Backpressure: none.
module crc32_dibit_step
  import bitorder_cksum_aggregate_pkg::*;
(
  input  logic [31:0] crc_in,
  input  dibit_t      dibit,
  output logic [31:0] crc_out
);

  assign crc_out = crc_bit_step(crc_bit_step(crc_in, dibit[0]), dibit[1]);

endmodule

// File: rtl/bitorder_cksum_aggregate.sv
// Purpose: RMII dibit reorder to MSB-first, frame CRC-32 check, and first-32-bit payload capture.
// Latency: reorder 4 cycles; ck_done 1 cycle after rx_axiiv falls; ag_axiov 1 cycle after 16th dibit.
// Backpressure: none; all paths accept one dibit per clock unconditionally.
module bitorder_cksum_aggregate
  import bitorder_cksum_aggregate_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  bitorder_cksum_aggregate_if.slave bus
);

  // A frame cut by reset is ignored until its valid drops, so its tail never looks like a new frame.
  logic rx_armed;
  logic rx_vld;
  assign rx_vld = bus.rx_axiiv & rx_armed;

  // Track whether the rx stream is at a frame boundary we may start on.
  always_ff @(posedge clk) begin
    if (rst)                rx_armed <= ~bus.rx_axiiv;
    else if (!bus.rx_axiiv) rx_armed <= 1'b1;
  end

  // ---------------- bit reorder ----------------
  // Ping-pong buffers hold d0..d2; d3 is the byte's [7:6] and is emitted directly.
  logic [2:0][1:0] ro_buf [2];
  logic            ro_wr_sel;
  logic            ro_rd_sel;
  logic [1:0]      ro_wr_cnt;
  logic [1:0]      ro_rd_cnt;
  logic            bo_vld_q;
  dibit_t          bo_dat_q;

  // Fill one buffer while the other drains; a partial byte is dropped when valid falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ro_buf[0] <= '0;
      ro_buf[1] <= '0;
      ro_wr_sel <= 1'b0;
      ro_rd_sel <= 1'b0;
      ro_wr_cnt <= 2'd0;
      ro_rd_cnt <= 2'd0;
      bo_vld_q  <= 1'b0;
      bo_dat_q  <= '0;
    end else begin
      bo_vld_q <= 1'b0;
      bo_dat_q <= '0;
      if (ro_rd_cnt != 2'd0) begin
        bo_vld_q  <= 1'b1;
        bo_dat_q  <= ro_buf[ro_rd_sel][ro_rd_cnt - 2'd1];
        ro_rd_cnt <= ro_rd_cnt - 2'd1;
      end
      if (rx_vld) begin
        if (ro_wr_cnt == 2'd3) begin
          // Drain of the previous byte has always finished by the time this byte completes.
          bo_vld_q  <= 1'b1;
          bo_dat_q  <= bus.rx_axiid;
          ro_rd_sel <= ro_wr_sel;
          ro_rd_cnt <= 2'd3;
          ro_wr_sel <= ~ro_wr_sel;
          ro_wr_cnt <= 2'd0;
        end else begin
          ro_buf[ro_wr_sel][ro_wr_cnt] <= bus.rx_axiid;
          ro_wr_cnt                    <= ro_wr_cnt + 2'd1;
        end
      end else begin
        ro_wr_cnt <= 2'd0;
      end
    end
  end

  assign bus.bo_axiov = bo_vld_q;
  assign bus.bo_axiod = bo_dat_q;

  // ---------------- checksum ----------------
  logic [31:0] crc_q;
  logic [31:0] crc_base;
  logic [31:0] crc_next;
  logic        rx_vld_q;
  logic        ck_done_q;
  logic        ck_kill_q;

  // First dibit of a frame starts from the initial value rather than the stale register.
  assign crc_base = rx_vld_q ? crc_q : CRC_INIT;

  crc32_dibit_step u_crc_step (
    .crc_in  (crc_base),
    .dibit   (bus.rx_axiid),
    .crc_out (crc_next)
  );

  // Accumulate CRC over the frame; flag the residue check on the cycle after valid falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= CRC_INIT;
      rx_vld_q  <= 1'b0;
      ck_done_q <= 1'b0;
      ck_kill_q <= 1'b0;
    end else begin
      rx_vld_q  <= rx_vld;
      ck_done_q <= rx_vld_q & ~rx_vld;
      if (rx_vld) crc_q <= crc_next;
      if (rx_vld_q && !rx_vld)      ck_kill_q <= (crc_q != CRC_RESIDUE);
      else if (rx_vld && !rx_vld_q) ck_kill_q <= 1'b0;
    end
  end

  assign bus.ck_done = ck_done_q;
  assign bus.ck_kill = ck_kill_q;

  // ---------------- aggregate ----------------
  logic        ag_armed;
  logic        ag_vld;
  logic [4:0]  ag_cnt;
  logic        ag_stb_q;
  logic [31:0] ag_word_q;

  assign ag_vld = bus.ag_axiiv & ag_armed;

  // Shift in the first AGG_DIBITS dibits of each frame, strobe once, then freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      ag_armed  <= ~bus.ag_axiiv;
      ag_cnt    <= 5'd0;
      ag_stb_q  <= 1'b0;
      ag_word_q <= '0;
    end else begin
      if (!bus.ag_axiiv) ag_armed <= 1'b1;
      ag_stb_q <= 1'b0;
      if (!ag_vld) begin
        ag_cnt <= 5'd0;
      end else if (ag_cnt != 5'(AGG_DIBITS)) begin
        ag_word_q <= {ag_word_q[29:0], bus.ag_axiid};
        ag_cnt    <= ag_cnt + 5'd1;
        ag_stb_q  <= (ag_cnt == 5'(AGG_DIBITS - 1));
      end
    end
  end

  assign bus.ag_axiov = ag_stb_q;
  assign bus.ag_axiod = ag_word_q;

endmodule

// File: tb/tb_bitorder_cksum_aggregate.sv
// Purpose: directed self-checking bench for reorder, CRC check and aggregate paths.
// Latency: checks each output on the exact cycle it is due.
// Backpressure: n/a; stimulus is valid-only.
`timescale 1ns/1ps
module tb_bitorder_cksum_aggregate;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  bitorder_cksum_aggregate_if bus ();

  bitorder_cksum_aggregate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame [$];
  logic [1:0]  ag_q  [$];
  logic [2:0]  rx_stim [$];
  logic [2:0]  bo_exp  [$];
  logic [31:0] fcs;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bo_vld"}, 32'(bus.bo_axiov), 32'd0);
    chk({tag, "_bo_dat"}, 32'(bus.bo_axiod), 32'd0);
    chk({tag, "_ag_vld"}, 32'(bus.ag_axiov), 32'd0);
    chk({tag, "_ag_dat"}, bus.ag_axiod, 32'd0);
    chk({tag, "_done"},   32'(bus.ck_done), 32'd0);
    chk({tag, "_kill"},   32'(bus.ck_kill), 32'd0);
  endtask

  // Ethernet FCS computed byte-wise: complement of the reflected CRC.
  function automatic logic [31:0] fcs_of_frame();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frame[i]) begin
      c = c ^ {24'h0, frame[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Broadcast dst, zero src, two payload bytes, FCS appended LSB byte first.
  task automatic build_frame(input logic [7:0] p0, input logic [7:0] p1);
    frame.delete();
    repeat (6) frame.push_back(8'hFF);
    repeat (6) frame.push_back(8'h00);
    frame.push_back(p0);
    frame.push_back(p1);
    fcs = fcs_of_frame();
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
  endtask

  // Stream the frame in wire order; ends in the first cycle with rx_axiiv low.
  task automatic send_rx_frame(input string tag);
    foreach (frame[i]) begin
      for (int k = 0; k < 4; k++) begin
        bus.rx_axiiv = 1'b1;
        bus.rx_axiid = frame[i][2*k +: 2];
        tick();
        if (i == 0 && k == 0) chk({tag, "_kill_clear"}, 32'(bus.ck_kill), 32'd0);
      end
    end
    bus.rx_axiiv = 1'b0;
    bus.rx_axiid = 2'b00;
  endtask

  task automatic check_done(input string tag, input logic kill_exp);
    chk({tag, "_done_early"}, 32'(bus.ck_done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(bus.ck_done), 32'd1);
    chk({tag, "_kill"}, 32'(bus.ck_kill), 32'(kill_exp));
    tick();
    chk({tag, "_done_once"}, 32'(bus.ck_done), 32'd0);
    chk({tag, "_kill_hold"}, 32'(bus.ck_kill), 32'(kill_exp));
  endtask

  // Drive rx_stim cycle by cycle and compare bo against bo_exp for the same cycle.
  task automatic run_bo(input string tag);
    for (int i = 0; i < rx_stim.size(); i++) begin
      bus.rx_axiiv = rx_stim[i][2];
      bus.rx_axiid = rx_stim[i][1:0];
      chk($sformatf("%s_vld%0d", tag, i), 32'(bus.bo_axiov), 32'(bo_exp[i][2]));
      if (bo_exp[i][2]) chk($sformatf("%s_dat%0d", tag, i), 32'(bus.bo_axiod), 32'(bo_exp[i][1:0]));
      tick();
    end
    bus.rx_axiiv = 1'b0;
    bus.rx_axiid = 2'b00;
  endtask

  task automatic push_ag_byte(input logic [7:0] b);
    ag_q.push_back(b[7:6]);
    ag_q.push_back(b[5:4]);
    ag_q.push_back(b[3:2]);
    ag_q.push_back(b[1:0]);
  endtask

  // Send n dibits from ag_q; a strobe is due exactly on cycle 16 when n >= 16.
  task automatic run_ag(input string tag, input int n, input logic [31:0] exp_word);
    for (int i = 0; i <= n + 1; i++) begin
      bus.ag_axiiv = (i < n);
      bus.ag_axiid = (i < n) ? ag_q[i] : 2'b00;
      chk($sformatf("%s_stb%0d", tag, i), 32'(bus.ag_axiov), 32'(n >= 16 && i == 16));
      if (n >= 16 && i == 16) chk({tag, "_word"}, bus.ag_axiod, exp_word);
      tick();
    end
    bus.ag_axiiv = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_axiiv = 1'b0;
    bus.rx_axiid = 2'b00;
    bus.ag_axiiv = 1'b0;
    bus.ag_axiid = 2'b00;

    // Reset state
    repeat (3) tick();
    chk_all_zero("rst_hold");
    rst = 1'b0;
    tick();
    chk_all_zero("rst_rel");

    // 0xA5 -> 10,10,01,01 at t+4..t+7
    rx_stim = '{3'b101, 3'b101, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    bo_exp  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b101, 3'b101, 3'b000};
    run_bo("ro_a5");

    // 0x12,0x34 back-to-back -> 8 contiguous outputs
    rx_stim = '{3'b110, 3'b100, 3'b101, 3'b100, 3'b100, 3'b101, 3'b111, 3'b100,
                3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    bo_exp  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b101, 3'b100, 3'b110,
                3'b100, 3'b111, 3'b101, 3'b100, 3'b000};
    run_bo("ro_1234");

    // New frame while draining, then a frame with a 2-dibit partial tail that must vanish
    rx_stim = '{3'b101, 3'b101, 3'b110, 3'b110, 3'b000, 3'b110, 3'b100, 3'b101,
                3'b100, 3'b111, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    bo_exp  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b101, 3'b101,
                3'b000, 3'b100, 3'b101, 3'b100, 3'b110, 3'b000, 3'b000, 3'b000};
    run_bo("ro_overlap");

    // Good frame, corrupted frame, good frame again
    build_frame(8'h56, 8'h78);
    send_rx_frame("crc_good");
    check_done("crc_good", 1'b0);
    repeat (2) tick();

    build_frame(8'h56, 8'h78);
    frame[12] = 8'h57;
    send_rx_frame("crc_bad");
    check_done("crc_bad", 1'b1);
    repeat (3) tick();
    chk("crc_bad_kill_idle", 32'(bus.ck_kill), 32'd1);

    build_frame(8'h56, 8'h78);
    send_rx_frame("crc_good2");
    check_done("crc_good2", 1'b0);
    repeat (2) tick();

    // Aggregate: payload then FCS, only the first 32 bits captured
    ag_q.delete();
    push_ag_byte(8'h56);
    push_ag_byte(8'h78);
    for (int i = 0; i < 4; i++) push_ag_byte(fcs[8*i +: 8]);
    run_ag("ag_fcs", 24, {8'h56, 8'h78, fcs[7:0], fcs[15:8]});
    chk("ag_fcs_frozen", bus.ag_axiod, {8'h56, 8'h78, fcs[7:0], fcs[15:8]});

    // Short frame gives no strobe, and its count does not carry into the next frame
    ag_q.delete();
    push_ag_byte(8'hAA);
    push_ag_byte(8'hBB);
    push_ag_byte(8'hCC);
    run_ag("ag_short", 10, 32'h0);

    ag_q.delete();
    push_ag_byte(8'hDE);
    push_ag_byte(8'hAD);
    push_ag_byte(8'hBE);
    push_ag_byte(8'hEF);
    run_ag("ag_16", 16, 32'hDEADBEEF);
    chk("ag_16_frozen", bus.ag_axiod, 32'hDEADBEEF);

    // Reset at dibit 10 of a frame, mid-drain of the second byte
    build_frame(8'h56, 8'h78);
    for (int i = 0; i < 10; i++) begin
      bus.rx_axiiv = 1'b1;
      bus.rx_axiid = frame[i / 4][2*(i % 4) +: 2];
      tick();
    end
    bus.rx_axiid = frame[2][5:4];
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid1");
    tick();
    chk_all_zero("rst_mid2");
    rst          = 1'b0;
    bus.rx_axiiv = 1'b0;
    bus.rx_axiid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abort_done%0d", i), 32'(bus.ck_done), 32'd0);
      chk($sformatf("abort_bo%0d", i), 32'(bus.bo_axiov), 32'd0);
    end

    send_rx_frame("crc_after_rst");
    check_done("crc_after_rst", 1'b0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitorder_cksum_aggregate.md
BITORDER_CKSUM_AGGREGATE -- requirements
Module: bitorder_cksum_aggregate

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 system/RMII 50 MHz clock; rst input 1 synchronous active-high reset.
REQ-002 The block SHALL have these data ports: rx_axiiv input 1 dibit-valid from the ether stage, high for the whole frame after SFD.
REQ-003 rx_axiid input 2 received dibit, wire order; bit0 is the earlier bit on the wire.
REQ-004 bo_axiov output 1 reordered-dibit valid.
REQ-005 bo_axiod output 2 reordered dibit, MSB-first within each byte.
REQ-006 ag_axiiv input 1 payload dibit valid from the external firewall stage.
REQ-007 ag_axiid input 2 payload dibit, MSB-first order.
REQ-008 ag_axiov output 1 one-cycle strobe: 32-bit word ready.
REQ-009 ag_axiod output 32 first 32 payload bits of the frame.
REQ-010 ck_done output 1 one-cycle end-of-frame strobe.
REQ-011 ck_kill output 1 FCS-bad flag, valid when ck_done is high.

Function -- bit reorder
REQ-012 Input dibits of each byte SHALL be numbered d0..d3 in arrival order, carrying byte bits [1:0],[3:2],[5:4],[7:6].
REQ-013 The reorder path SHALL emit each completed byte as [7:6],[5:4],[3:2],[1:0] on four consecutive cycles with bo_axiov high.
REQ-014 If d0..d3 arrive at cycles t..t+3, outputs SHALL appear at t+4..t+7; the fixed latency is 4 cycles.
REQ-015 The reorder path SHALL use a ping-pong pair of byte buffers, so continuous input produces continuous output with no gaps.
REQ-016 A frame's dibit count is the number of rx_axiiv-high cycles; a trailing partial byte (count not a multiple of 4) SHALL be discarded.
REQ-017 The last full byte SHALL still be emitted after rx_axiiv falls.
REQ-018 A new frame starting while the previous frame's last byte is draining SHALL be handled without loss.

Function -- checksum
REQ-019 The checksum path SHALL compute CRC-32 in reflected form: polynomial 0xEDB88320, right-shifting, initial value 0xFFFFFFFF, no final XOR.
REQ-020 Per valid cycle it SHALL process rx_axiid[0] then rx_axiid[1], i.e. two bit-steps per clock.
REQ-021 The CRC SHALL cover every dibit from frame start through the FCS.
REQ-022 The CRC register SHALL reload to 0xFFFFFFFF on the first valid dibit of each frame (rx_axiiv rising).
REQ-023 ck_done SHALL pulse for exactly one cycle, the cycle after rx_axiiv falls.
REQ-024 ck_kill SHALL be registered together with ck_done: 1 if the final CRC register is not 0xDEBB20E3, else 0.
REQ-025 ck_kill SHALL hold its value until the next frame's first valid dibit, then clear to 0.

Function -- aggregate
REQ-026 The aggregate path SHALL shift ag_axiid in MSB-first: ag_axiod <= {ag_axiod[29:0], ag_axiid}.
REQ-027 It SHALL count valid dibits from 0; on the 16th dibit of a frame it SHALL assert ag_axiov for one cycle, with the 32-bit word valid that same cycle.
REQ-028 After the 16th dibit, all further dibits of the frame SHALL be ignored: no further strobes and ag_axiod frozen.
REQ-029 ag_axiiv low SHALL reset the dibit count to 0; ag_axiod keeps its last value.
REQ-030 Frames with fewer than 16 valid dibits SHALL produce no strobe.

Reset
REQ-031 rst SHALL clear all buffers, counters and state.
REQ-032 During and after reset, outputs SHALL be: bo_axiov=0, bo_axiod=0, ag_axiov=0, ag_axiod=0, ck_done=0, ck_kill=0.
REQ-033 The CRC register SHALL reset to 0xFFFFFFFF.
REQ-034 A reset asserted mid-frame SHALL abort that frame.
REQ-035 After an aborted frame, no ck_done and no residual bo output SHALL be produced.
REQ-036 The next rx_axiiv rise after reset SHALL start a fresh frame.

Structure
REQ-037 A shared package SHALL hold: CRC_POLY_REFL=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3, AGG_DIBITS=16.
REQ-038 The three paths SHALL be independent; only clk and rst are shared.
REQ-039 The CRC dibit-step function SHALL be one sub-module named crc32_dibit_step: combinational, taking the register and a dibit and returning the next register.

Verification
REQ-040 Byte 0xA5 streamed as dibits 01,01,10,10 -> bo_axiod = 10,10,01,01 on cycles t+4..t+7 with bo_axiov high.
REQ-041 Bytes 0x12 then 0x34 back-to-back -> 8 contiguous output cycles giving 00,01,00,10,00,11,01,00.
REQ-042 Broadcast frame with src MAC 0, 2-byte payload 0x5678 and correct FCS -> ck_done pulses once the cycle after rx_axiiv falls, with ck_kill=0.
REQ-043 The same frame with one flipped payload bit -> ck_done pulses with ck_kill=1.
REQ-044 ag stream 0x5678 followed by the FCS dibits -> a single ag_axiov strobe with ag_axiod = 0x5678 followed by the first two FCS bytes; no second strobe.
REQ-045 Reset asserted at dibit 10 of a frame -> all outputs 0, no ck_done; the next full frame is processed correctly.
